// File: rtl/fetch_unit.sv
// Program counter and fetch stage feeding a one-entry instruction register with valid/ready output.
// Optional build macro FETCH_NOP_SKIP_EN: zero (NOP) instructions are skipped instead of presented.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  pc_address,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic               halted
);

  typedef enum logic {FETCH, HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               load;

  assign load = !valid_q || instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      // Frozen except that a pending instruction may still be consumed.
      HALT: begin
        if (load) valid_d = 1'b0;
      end
      FETCH: begin
        if (halt_req) begin
          state_d = HALT;
          if (load) valid_d = 1'b0;
        end else if (branch_en) begin
          pc_d    = {branch_target[ADDR_W-1:1], 1'b0};
          valid_d = 1'b0;
        end else if (load) begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
`ifdef FETCH_NOP_SKIP_EN
          if (instr_in == '0) begin
            valid_d = 1'b0;
          end else begin
            instr_d = instr_in;
            valid_d = 1'b1;
          end
`else
          instr_d = instr_in;
          valid_d = 1'b1;
`endif
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_address  = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan scenarios followed by randomized traffic,
// checked against a transaction-level reference model driven by the same stimulus.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc_address;
  logic [7:0] instr_in;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_en;
  logic [7:0] branch_target;
  logic       halt_req;
  logic       halted;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_address(pc_address), .instr_in(instr_in),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_en(branch_en), .branch_target(branch_target), .halt_req(halt_req),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always_comb instr_in = mem[pc_address];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: next fetch address, held instruction, halted flag.
  int       m_pc;
  int       m_instr;
  bit       m_valid;
  bit       m_halt;
  int       exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_edge();
    bit slot_free;
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_halt = 0;
      return;
    end
    slot_free = !m_valid || instr_ready;
    if (m_valid && instr_ready) exp_q.push_back(m_instr);
    if (m_halt) begin
      if (slot_free) m_valid = 0;
    end else if (halt_req) begin
      m_halt = 1;
      if (slot_free) m_valid = 0;
    end else if (branch_en) begin
      m_pc = (int'(branch_target) / 2) * 2;
      m_valid = 0;
    end else if (slot_free) begin
`ifdef FETCH_NOP_SKIP_EN
      if (mem[m_pc] == 8'h00) m_valid = 0;
      else begin m_instr = int'(mem[m_pc]); m_valid = 1; end
`else
      m_instr = int'(mem[m_pc]);
      m_valid = 1;
`endif
      m_pc = (m_pc + 2) % 256;
    end
  endtask

  task automatic cyc(input bit r, input bit rdy, input bit br, input int tgt, input bit hlt);
    rst_n = r; instr_ready = rdy; branch_en = br; branch_target = 8'(tgt); halt_req = hlt;
    model_edge();
    @(posedge clk);
    #2;
    chk("pc_address", int'(pc_address), m_pc);
    chk("instr_valid", int'(instr_valid), int'(m_valid));
    chk("instr_out", int'(instr_out), m_instr);
    chk("halted", int'(halted), int'(m_halt));
  endtask

  // Monitor: every completed handshake must deliver the next expected instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL handshake: got %0h expected none at %0t", instr_out, $time);
      end else begin
        chk("handshake", int'(instr_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[2] = 8'hD3; mem[4] = 8'h50; mem[6] = 8'hD1; mem[8] = 8'h51; mem[10] = 8'h10;
    m_pc = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    rst_n = 0; instr_ready = 0; branch_en = 0; branch_target = 0; halt_req = 0;

    // Reset and streaming
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_rst_pc", int'(pc_address), 0);
    chk("t1_rst_valid", int'(instr_valid), 0);
    chk("t1_rst_halted", int'(halted), 0);
    cyc(1, 1, 0, 0, 0);
    chk("t1_pc2", int'(pc_address), 2);
    cyc(1, 1, 0, 0, 0);
    chk("t1_d3", int'(instr_out), 8'hD3);

    // Stall holds D3
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t2_hold_instr", int'(instr_out), 8'hD3);
      chk("t2_hold_pc", int'(pc_address), 4);
    end
    cyc(1, 1, 0, 0, 0);
    chk("t2_next", int'(instr_out), 8'h50);

    // Branch during stall squashes 50
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 8'h07, 0);
    chk("t3_squash", int'(instr_valid), 0);
    chk("t3_pc", int'(pc_address), 6);
    cyc(1, 1, 0, 0, 0);
    chk("t3_target", int'(instr_out), 8'hD1);

    // Wrap-around
    cyc(1, 1, 1, 8'hFC, 0);
    chk("t4_pc_fc", int'(pc_address), 8'hFC);
    cyc(1, 1, 0, 0, 0);
    chk("t4_pc_fe", int'(pc_address), 8'hFE);
    cyc(1, 1, 0, 0, 0);
    chk("t4_pc_00", int'(pc_address), 8'h00);
    cyc(1, 1, 0, 0, 0);
    chk("t4_pc_02", int'(pc_address), 8'h02);
    cyc(1, 1, 0, 0, 0);
    chk("t4_d3", int'(instr_out), 8'hD3);

    // Halt with pending instruction
    cyc(1, 1, 1, 8'h08, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t5_51", int'(instr_out), 8'h51);
    cyc(1, 0, 0, 0, 1);
    chk("t5_halted", int'(halted), 1);
    chk("t5_pending", int'(instr_valid), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t5_consumed", int'(instr_valid), 0);
    chk("t5_pc_frozen", int'(pc_address), 8'h0A);
    cyc(1, 1, 1, 8'h20, 0);
    chk("t5_branch_ignored", int'(pc_address), 8'h0A);

    // Reset out of HALT
    cyc(0, 0, 0, 0, 0);
    chk("t6_halted", int'(halted), 0);
    chk("t6_pc", int'(pc_address), 0);
    cyc(1, 1, 0, 0, 0);
    chk("t6_resume_pc", int'(pc_address), 2);

    // Randomized traffic over a denser memory image
    for (int i = 12; i < 256; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      bit r, rdy, br, hl;
      r   = !(($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0));
      rdy = r && ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 9) == 0);
      hl  = ($urandom_range(0, 59) == 0);
      cyc(r, rdy, br, int'($urandom_range(0, 255)), hl);
    end
    cyc(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
